tcdm_arb_tree_rr: RTL

// N-master to 1-bank arbitration node of the TCDM log interconnect. Sits directly downstream
// of the priority flag generator: consumes its rotating PRIO flag, picks one requester per cycle,

---
 rtl/tcdm_arb_tree_rr.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tcdm_arb_tree_rr.sv
// N-master to 1-bank round-robin arbitration node with a single registered output slot.
// Optional contention counter is built when ARB_PERF_CNT_EN is defined.
module tcdm_arb_tree_rr #(
  parameter int N_MASTER   = 4,
  parameter int LOG_N      = $clog2(N_MASTER),
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_MASTER-1:0]            data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_MASTER-1:0]            data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
  output logic [N_MASTER-1:0]            data_gnt_o,
  input  logic [LOG_N-1:0]               prio_flag_i,
  output logic                           flag_req_o,
  output logic                           flag_gnt_o,
  output logic                           mem_req_o,
  output logic [ADDR_WIDTH-1:0]          mem_add_o,
  output logic                           mem_wen_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  output logic [BE_WIDTH-1:0]            mem_be_o,
  output logic [LOG_N-1:0]               mem_id_o,
  input  logic                           mem_gnt_i,
  output logic [31:0]                    conflict_cnt_o
);

  logic                  rdy;
  logic                  any_req;
  logic                  grant;
  logic [LOG_N-1:0]      prio_eff;
  logic [LOG_N-1:0]      winner;

  logic [ADDR_WIDTH-1:0] add_arr   [N_MASTER];
  logic [DATA_WIDTH-1:0] wdata_arr [N_MASTER];
  logic [BE_WIDTH-1:0]   be_arr    [N_MASTER];

  for (genvar g = 0; g < N_MASTER; g++) begin : g_unpack
    assign add_arr[g]   = data_add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = data_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]    = data_be_i[g*BE_WIDTH +: BE_WIDTH];
  end

  // Only a non-power-of-two master count can see an out-of-range flag.
  if ((2 ** LOG_N) > N_MASTER) begin : g_prio_clamp
    assign prio_eff = ({1'b0, prio_flag_i} >= (LOG_N+1)'(N_MASTER)) ? '0 : prio_flag_i;
  end else begin : g_prio_direct
    assign prio_eff = prio_flag_i;
  end

  assign rdy     = ~mem_req_o | mem_gnt_i;
  assign any_req = |data_req_i;
  assign grant   = any_req & rdy;

  always_comb begin
    logic [LOG_N:0] idx;
    logic           found;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      idx = {1'b0, prio_eff} + (LOG_N+1)'(k);
      if (idx >= (LOG_N+1)'(N_MASTER)) begin
        idx = idx - (LOG_N+1)'(N_MASTER);
      end
      if (!found && data_req_i[idx[LOG_N-1:0]]) begin
        winner = idx[LOG_N-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    data_gnt_o = '0;
    if (grant) begin
      data_gnt_o[winner] = 1'b1;
    end
  end

  assign flag_req_o = any_req;
  assign flag_gnt_o = grant;

  // A new grant overwrites the slot even while it drains, so there is no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req_o   <= 1'b0;
      mem_add_o   <= '0;
      mem_wen_o   <= 1'b0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      mem_id_o    <= '0;
    end else if (grant) begin
      mem_req_o   <= 1'b1;
      mem_add_o   <= add_arr[winner];
      mem_wen_o   <= data_wen_i[winner];
      mem_wdata_o <= wdata_arr[winner];
      mem_be_o    <= be_arr[winner];
      mem_id_o    <= winner;
    end else if (mem_gnt_i) begin
      mem_req_o   <= 1'b0;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt;
  logic        multi_req;

  assign multi_req = ($countones(data_req_i) >= 2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (multi_req && grant && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt;
`else
  assign conflict_cnt_o = 32'h0;
`endif

endmodule
